// File: rtl/wave_pkg.sv
// Shared constants and capture FSM state type for the waveform capture path and the VGA renderer.
package wave_pkg;

    localparam int WAVE_DEPTH   = 640;
    localparam int WAVE_AW      = 10;
    localparam int WAVE_DW      = 8;
    localparam int WAVE_AUTO_TO = 4096;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/wave_capture_if.sv
// Sample, trigger, frame and display-read signals between the ADC/VGA side and the capture buffer.
interface wave_capture_if
    import wave_pkg::*;
#(
    parameter int AW = WAVE_AW,
    parameter int DW = WAVE_DW
);

    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic [DW-1:0] trig_level;
    logic          frame_sync;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          bank_sel;
    logic          cap_busy;
    logic          cap_done;

    modport master (
        output sample_data, sample_valid, trig_level, frame_sync, rd_addr,
        input  rd_data, bank_sel, cap_busy, cap_done
    );

    modport slave (
        input  sample_data, sample_valid, trig_level, frame_sync, rd_addr,
        output rd_data, bank_sel, cap_busy, cap_done
    );

endinterface

// File: rtl/wave_dpram.sv
// Ping-pong sample store: 2*DEPTH words addressed as {bank, addr}, one write port, one registered read port.
module wave_dpram
    import wave_pkg::*;
#(
    parameter int DEPTH = WAVE_DEPTH,
    parameter int AW    = WAVE_AW,
    parameter int DW    = WAVE_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW:0]   raddr,
    output logic [DW-1:0] rdata
);

    localparam int          LW      = $clog2(2 * DEPTH);
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [2*DEPTH];

    // Bank 1 is packed directly after bank 0 so no words are wasted when DEPTH < 2^AW.
    function automatic logic [LW-1:0] lin_addr(input logic [AW:0] a);
        logic [LW-1:0] base;
        base = a[AW] ? LW'(DEPTH) : '0;
        return base + LW'(a[AW-1:0]);
    endfunction

    always_ff @(posedge clk) begin
        if (we) begin
            mem[lin_addr(waddr)] <= wdata;
        end
        if ({1'b0, raddr[AW-1:0]} < DEPTH_X) begin
            rdata <= mem[lin_addr(raddr)];
        end
    end

endmodule

// File: rtl/wave_capture.sv
// Triggered waveform capture into a ping-pong RAM; banks swap only on frame_sync after a full capture.
// Optional auto-trigger timeout is enabled with `define WAVE_CAP_AUTO_TRIG_EN.
module wave_capture
    import wave_pkg::*;
#(
    parameter int DEPTH   = WAVE_DEPTH,
    parameter int AW      = WAVE_AW,
    parameter int DW      = WAVE_DW,
    parameter int AUTO_TO = WAVE_AUTO_TO
) (
    input logic           sys_clk,
    input logic           rst_n,
    wave_capture_if.slave cap
);

    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    cap_state_t    state;
    logic [AW-1:0] wr_ptr;
    logic          bank_sel;
    logic          busy;
    logic          done;
    logic          prev_ok;
    logic [DW-1:0] prev_sample;
    logic          edge_hit;
    logic          trig;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic          rd_zero_p1;
    logic [DW-1:0] ram_q_p1;

    function automatic logic level_cross(input logic [DW-1:0] prev,
                                         input logic [DW-1:0] cur,
                                         input logic [DW-1:0] level);
        return (prev < level) && (cur >= level);
    endfunction

    assign edge_hit = cap.sample_valid && prev_ok &&
                      level_cross(prev_sample, cap.sample_data, cap.trig_level);

`ifdef WAVE_CAP_AUTO_TRIG_EN
    localparam int CW = AW + 3;

    logic [CW-1:0] auto_cnt;
    logic          auto_hit;

    assign auto_hit = cap.sample_valid && (auto_cnt == CW'(AUTO_TO - 1));
    assign trig     = edge_hit || auto_hit;

    // Held at zero outside ARM, so every ARM entry starts a fresh timeout.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (state != ARM || trig) begin
            auto_cnt <= '0;
        end else if (cap.sample_valid) begin
            auto_cnt <= auto_cnt + CW'(1);
        end
    end
`else
    logic auto_unused;

    assign auto_unused = (AUTO_TO == 0);
    assign trig        = edge_hit;
`endif

    assign cap_we   = cap.sample_valid && ((state == ARM && trig) || state == CAPTURE);
    assign cap_addr = (state == ARM) ? '0 : wr_ptr;

    always_ff @(posedge sys_clk) begin
        if (cap.sample_valid) begin
            prev_sample <= cap.sample_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARM;
            wr_ptr   <= '0;
            bank_sel <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            prev_ok  <= 1'b0;
        end else begin
            if (cap.sample_valid) begin
                prev_ok <= 1'b1;
            end
            case (state)
                ARM: begin
                    if (trig) begin
                        state  <= CAPTURE;
                        wr_ptr <= AW'(1);
                        busy   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cap.sample_valid) begin
                        if (wr_ptr == AW'(DEPTH - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end
                end
                DONE: begin
                    // ARM entry drops prev_ok so a trigger needs two fresh samples.
                    if (cap.frame_sync) begin
                        state    <= ARM;
                        bank_sel <= ~bank_sel;
                        done     <= 1'b0;
                        wr_ptr   <= '0;
                        prev_ok  <= 1'b0;
                    end
                end
                default: begin
                    state <= ARM;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    wave_dpram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk   (sys_clk),
        .we    (cap_we),
        .waddr ({bank_sel, cap_addr}),
        .wdata (cap.sample_data),
        .raddr ({~bank_sel, cap.rd_addr}),
        .rdata (ram_q_p1)
    );

    // p1: registered display read; out-of-range columns are forced to zero.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_zero_p1 <= 1'b1;
        end else begin
            rd_zero_p1 <= ({1'b0, cap.rd_addr} >= DEPTH_X);
        end
    end

    assign cap.rd_data  = rd_zero_p1 ? '0 : ram_q_p1;
    assign cap.bank_sel = bank_sel;
    assign cap.cap_busy = busy;
    assign cap.cap_done = done;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: trigger, full capture, bank swap rules, read range and async reset.
module tb_wave_capture;

    localparam int DEPTH = 640;
    localparam int AW    = 10;
    localparam int DW    = 8;
`ifdef WAVE_CAP_AUTO_TRIG_EN
    localparam int AUTO_TO = 16;
`else
    localparam int AUTO_TO = 4096;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    wave_capture_if #(.AW(AW), .DW(DW)) cap_if ();

    wave_capture #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .DW      (DW),
        .AUTO_TO (AUTO_TO)
    ) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .cap     (cap_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic valid, input logic [DW-1:0] data, input logic fs);
        cap_if.sample_valid = valid;
        cap_if.sample_data  = data;
        cap_if.frame_sync   = fs;
        @(posedge clk);
        #1;
        cap_if.sample_valid = 1'b0;
        cap_if.frame_sync   = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] data);
        step(1'b1, data, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [DW-1:0] exp);
        cap_if.rd_addr = AW'(addr);
        @(posedge clk);
        #1;
        check_eq(tag, 32'(cap_if.rd_data), 32'(exp));
    endtask

    task automatic arm_trigger();
        send(8'h10);
        send(8'h90);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        cap_if.sample_valid = 1'b0;
        cap_if.sample_data  = '0;
        cap_if.trig_level   = 8'h80;
        cap_if.frame_sync   = 1'b0;
        cap_if.rd_addr      = AW'(5);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rd_data", 32'(cap_if.rd_data), 32'h0);
        check_eq("rst_bank_sel", 32'(cap_if.bank_sel), 32'h0);
        check_eq("rst_cap_busy", 32'(cap_if.cap_busy), 32'h0);
        check_eq("rst_cap_done", 32'(cap_if.cap_done), 32'h0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Capture 1 into bank 0: trigger on 0x80, then ramp.
        send(8'h70);
        send(8'h78);
        check_eq("arm_below_level", 32'(cap_if.cap_busy), 32'h0);
        send(8'h80);
        check_eq("trig_busy", 32'(cap_if.cap_busy), 32'h1);
        check_eq("trig_done", 32'(cap_if.cap_done), 32'h0);
        for (int i = 1; i < DEPTH - 1; i++) send(8'(i));
        check_eq("cap1_pre_last_busy", 32'(cap_if.cap_busy), 32'h1);
        check_eq("cap1_pre_last_done", 32'(cap_if.cap_done), 32'h0);
        send(8'(DEPTH - 1));
        check_eq("cap1_done", 32'(cap_if.cap_done), 32'h1);
        check_eq("cap1_busy_off", 32'(cap_if.cap_busy), 32'h0);
        send(8'hFF);
        check_eq("done_hold", 32'(cap_if.cap_done), 32'h1);
        check_eq("done_no_swap", 32'(cap_if.bank_sel), 32'h0);
        step(1'b0, 8'h00, 1'b1);
        check_eq("swap1_bank_sel", 32'(cap_if.bank_sel), 32'h1);
        check_eq("swap1_done_off", 32'(cap_if.cap_done), 32'h0);
        rd_chk("cap1_addr0", 0, 8'h80);
        rd_chk("cap1_addr100", 100, 8'h64);
        rd_chk("cap1_addr639", 639, 8'h7F);
        rd_chk("oob_addr640", 640, 8'h00);
        rd_chk("oob_addr1023", 1023, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        check_eq("arm_fs_ignored", 32'(cap_if.bank_sel), 32'h1);

`ifndef WAVE_CAP_AUTO_TRIG_EN
        for (int i = 0; i < 40; i++) begin
            send(8'h90);
            step(1'b0, 8'h00, 1'b0);
        end
        check_eq("no_edge_no_trig", 32'(cap_if.cap_busy), 32'h0);
`endif

        // Capture 2 into bank 1 with frame_sync mid-capture and on the final write.
        arm_trigger();
        check_eq("cap2_trig", 32'(cap_if.cap_busy), 32'h1);
        for (int k = 1; k < DEPTH - 1; k++) begin
            step(1'b1, 8'(k + 3), k == 300);
            if (k == 300) begin
                check_eq("midcap_fs_bank", 32'(cap_if.bank_sel), 32'h1);
                check_eq("midcap_fs_busy", 32'(cap_if.cap_busy), 32'h1);
            end
        end
        step(1'b1, 8'(DEPTH - 1 + 3), 1'b1);
        check_eq("last_fs_done", 32'(cap_if.cap_done), 32'h1);
        check_eq("last_fs_no_swap", 32'(cap_if.bank_sel), 32'h1);
        rd_chk("cap1_still_shown", 5, 8'h05);
        step(1'b0, 8'h00, 1'b1);
        check_eq("swap2_bank_sel", 32'(cap_if.bank_sel), 32'h0);
        rd_chk("cap2_addr0", 0, 8'h90);
        rd_chk("cap2_addr300", 300, 8'h2F);
        rd_chk("cap2_addr639", 639, 8'h82);

        // Capture 3 into bank 0, then swap so bank_sel is 1 again.
        arm_trigger();
        for (int k = 1; k < DEPTH; k++) send(8'h55);
        check_eq("cap3_done", 32'(cap_if.cap_done), 32'h1);
        step(1'b0, 8'h00, 1'b1);
        check_eq("swap3_bank_sel", 32'(cap_if.bank_sel), 32'h1);
        rd_chk("cap3_addr1", 1, 8'h55);

        // Capture 4 into bank 1, interrupted by asynchronous reset.
        arm_trigger();
        for (int k = 1; k < 200; k++) send(8'h33);
        check_eq("cap4_busy", 32'(cap_if.cap_busy), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", 32'(cap_if.cap_busy), 32'h0);
        check_eq("async_rst_bank", 32'(cap_if.bank_sel), 32'h0);
        check_eq("async_rst_done", 32'(cap_if.cap_done), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_chk("post_rst_oob700", 700, 8'h00);
        rd_chk("post_rst_addr0", 0, 8'h90);
        rd_chk("post_rst_addr100", 100, 8'h33);
        rd_chk("ram_kept_addr500", 500, 8'hF7);

`ifdef WAVE_CAP_AUTO_TRIG_EN
        for (int i = 0; i < AUTO_TO - 1; i++) send(8'h20);
        check_eq("auto_before_to", 32'(cap_if.cap_busy), 32'h0);
        send(8'h20);
        check_eq("auto_fire", 32'(cap_if.cap_busy), 32'h1);
`else
        send(8'h90);
        check_eq("rst_clears_prev_ok", 32'(cap_if.cap_busy), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
